ps2_frame_ctrl: RTL and testbench
=================================

# ps2_frame_ctrl

PS/2 receive controller that sequences frame capture from the keyboard lines into the fpgaclk domain. It validates start, parity and stop bits, enforces an inter-edge timeout, and folds the E0 (extended) and F0 (break) prefixes into a single key event. Events are presented on a valid/ready interface to the scancode register and display path, replacing free-running bit counting with a checked, restartable state machine.

## Interface
- TIMEOUT_CYC, default 5000: fpgaclk cycles allowed between successive ps2clk falling edges inside a frame (100 us at 50 MHz).
- CNT_W, default 13: width of the timeout counter; must hold TIMEOUT_CYC.

- fpgaclk  in  1  system clock; all state is on its rising edge.
- rstreg  in  1  reset, asynchronous, active-high.
- ps2clk  in  1  raw PS/2 clock pin, asynchronous to fpgaclk.
- ps2data  in  1  raw PS/2 data pin, asynchronous to fpgaclk.
- key_ready  in  1  consumer accepts the event when high with key_valid.
- key_valid  out  1  event pending; held until accepted.
- key_code  out  8  final, non-prefix scancode byte.
- key_break  out  1  F0 preceded key_code (key release).
- key_ext  out  1  E0 preceded key_code.
- frame_err  out  1  one-cycle pulse on an aborted frame.
- err_code  out  2  cause of the last error: 01 parity, 10 stop, 11 timeout; 00 after reset; held between errors.
- overrun  out  1  sticky: an event was dropped because key_valid was pending.
- busy  out  1  FSM is not in IDLE.

## Operation
- ps2clk and ps2data each pass through a 2-flop synchronizer. A third flop on clk gives fall = clk_d & ~clk_s. Bits are sampled from the synchronized data on fall.
- FSM states:
  - IDLE: on fall with data=0 (start bit), go to DATA with bit_cnt=0. On fall with data=1, stay in IDLE (glitch/noise).
  - DATA: on fall, shift the bit in LSB-first (shreg <= {data, shreg[7:1]}) and increment bit_cnt. After the 8th bit, go to PARITY.
  - PARITY: on fall, capture the parity bit and go to STOP.
  - STOP: on fall, check the frame:
    - data=0: frame error, err_code=10.
    - Otherwise, if ^{shreg,parity} != 1 (odd parity), frame error, err_code=01.
    - Otherwise the byte is good. Go to IDLE in all cases.
- Timeout: tcnt clears on every fall and in IDLE, and increments otherwise. When tcnt reaches TIMEOUT_CYC-1 outside IDLE: frame error with err_code=11, go to IDLE.
- Good byte handling:
  - E0 sets ext_f.
  - F0 sets brk_f.
  - Any other byte produces an event {byte, brk_f, ext_f} and clears both flags.
- Event emission:
  - If key_valid=0, load the outputs and set key_valid.
  - If key_valid=1 and this is not the handshake cycle, drop the event and set overrun.
- Handshake: key_valid & key_ready clears key_valid at the next edge. On an accepted handshake, overrun clears unless a drop occurs in the same cycle.
- Simultaneous accept and new event in the same cycle: the new event loads and key_valid stays 1; no overrun.
- Any frame error clears ext_f and brk_f, leaves a pending event untouched, and pulses frame_err for exactly one cycle.

## Timing
- Reset (async): FSM=IDLE, bit_cnt=0, tcnt=0, shreg=0, flags=0, synchronizers=1 (idle bus), key_valid=0, key_code=00, key_break=0, key_ext=0, frame_err=0, err_code=00, overrun=0, busy=0.
- A pin falling edge produces fall 3 fpgaclk cycles later (±1 for metastability).
- The cycle after fall is registered on the stop bit: key_valid=1 or frame_err=1. Pin-to-event latency is 4 cycles.
- A prefix byte produces no output change.
- One frame is 11 falls; no minimum spacing other than 1 fall per cycle.
- Reset mid-frame abandons the partial byte and flags; no error is reported.

## Test plan
- Frame 0x1C, parity 0, stop 1, key_ready=1 → one key_valid cycle: code 1C, break 0, ext 0; busy 1→0 after the stop bit.
- Sequence E0, F0, 75 with key_ready=0 → key_valid holds code 75, break 1, ext 1 until key_ready pulses. Prefixes alone give no key_valid.
- Frame 0x1C with parity 1 → frame_err pulse, err_code 01, no event. A following F0 1C yields break 1 with ext 0.
- Start bit, then 4 data bits, then ps2clk held high for TIMEOUT_CYC cycles → frame_err, err_code 11, IDLE. The next valid frame 0x29 decodes correctly.
- Two events 1C then 32 with key_ready=0 → key_code stays 1C, overrun=1. Accepting clears key_valid and overrun. Accept coincident with a new event → new code shown, overrun 0.
- rstreg pulsed after the 5th data bit → all outputs at reset values. The next frame 0x5A decodes correctly.

Source files
------------

// File: rtl/ps2_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_frame_ctrl
//  Description : PS/2 keyboard receive controller. Synchronizes the PS/2
//                lines into the fpgaclk domain, checks start/parity/stop
//                bits and the inter-edge timeout, folds E0/F0 prefixes into
//                one key event and presents it on a valid/ready interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_frame_ctrl #(
   parameter int TIMEOUT_CYC = 5000,
   parameter int CNT_W       = 13
) (
   input  logic       fpgaclk,
   input  logic       rstreg,
   input  logic       ps2clk,
   input  logic       ps2data,
   input  logic       key_ready,
   output logic       key_valid,
   output logic [7:0] key_code,
   output logic       key_break,
   output logic       key_ext,
   output logic       frame_err,
   output logic [1:0] err_code,
   output logic       overrun,
   output logic       busy
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] c_tmo_last = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [7:0]       c_ext_byte = 8'hE0;
   localparam logic [7:0]       c_brk_byte = 8'hF0;
   localparam logic [1:0]       c_err_par  = 2'b01;
   localparam logic [1:0]       c_err_stop = 2'b10;
   localparam logic [1:0]       c_err_tmo  = 2'b11;

   // synchronizer flops; reset to 1 because an idle PS/2 bus is high
   logic r_clk_m, r_clk_s, r_clk_d;
   logic r_dat_m, r_dat_s;

   state_t           r_state;
   logic [2:0]       r_bit_cnt;
   logic [CNT_W-1:0] r_tcnt;
   logic [7:0]       r_shreg;
   logic             r_parity;
   logic             r_ext_f;
   logic             r_brk_f;
   logic             r_key_valid;
   logic [7:0]       r_key_code;
   logic             r_key_break;
   logic             r_key_ext;
   logic             r_frame_err;
   logic [1:0]       r_err_code;
   logic             r_overrun;

   logic w_fall;
   logic w_accept;
   logic w_timeout;

   assign w_fall    = r_clk_d & ~r_clk_s;
   assign w_accept  = r_key_valid & key_ready;
   assign w_timeout = (r_state != S_IDLE) && !w_fall && (r_tcnt == c_tmo_last);

   // Two-flop synchronizers plus a delay flop for falling-edge detection
   always_ff @(posedge fpgaclk or posedge rstreg) begin
      if (rstreg) begin
         r_clk_m <= 1'b1;
         r_clk_s <= 1'b1;
         r_clk_d <= 1'b1;
         r_dat_m <= 1'b1;
         r_dat_s <= 1'b1;
      end else begin
         r_clk_m <= ps2clk;
         r_clk_s <= r_clk_m;
         r_clk_d <= r_clk_s;
         r_dat_m <= ps2data;
         r_dat_s <= r_dat_m;
      end
   end

   // Frame FSM, timeout counter, prefix folding and event handshake
   always_ff @(posedge fpgaclk or posedge rstreg) begin
      if (rstreg) begin
         r_state     <= S_IDLE;
         r_bit_cnt   <= 3'd0;
         r_tcnt      <= '0;
         r_shreg     <= 8'h00;
         r_parity    <= 1'b0;
         r_ext_f     <= 1'b0;
         r_brk_f     <= 1'b0;
         r_key_valid <= 1'b0;
         r_key_code  <= 8'h00;
         r_key_break <= 1'b0;
         r_key_ext   <= 1'b0;
         r_frame_err <= 1'b0;
         r_err_code  <= 2'b00;
         r_overrun   <= 1'b0;
      end else begin
         r_frame_err <= 1'b0;

         // accepted handshake; a load later in this block overrides it
         if (w_accept) begin
            r_key_valid <= 1'b0;
            r_overrun   <= 1'b0;
         end

         if (r_state == S_IDLE || w_fall)
            r_tcnt <= '0;
         else
            r_tcnt <= r_tcnt + CNT_W'(1);

         if (w_timeout) begin
            r_state     <= S_IDLE;
            r_frame_err <= 1'b1;
            r_err_code  <= c_err_tmo;
            r_ext_f     <= 1'b0;
            r_brk_f     <= 1'b0;
         end else if (w_fall) begin
            case (r_state)
               S_IDLE: begin
                  // a high level here is a stray edge, not a start bit
                  if (!r_dat_s) begin
                     r_state   <= S_DATA;
                     r_bit_cnt <= 3'd0;
                  end
               end
               S_DATA: begin
                  r_shreg   <= {r_dat_s, r_shreg[7:1]};
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7)
                     r_state <= S_PARITY;
               end
               S_PARITY: begin
                  r_parity <= r_dat_s;
                  r_state  <= S_STOP;
               end
               S_STOP: begin
                  r_state <= S_IDLE;
                  if (!r_dat_s) begin
                     r_frame_err <= 1'b1;
                     r_err_code  <= c_err_stop;
                     r_ext_f     <= 1'b0;
                     r_brk_f     <= 1'b0;
                  end else if (!(^{r_shreg, r_parity})) begin
                     r_frame_err <= 1'b1;
                     r_err_code  <= c_err_par;
                     r_ext_f     <= 1'b0;
                     r_brk_f     <= 1'b0;
                  end else if (r_shreg == c_ext_byte) begin
                     r_ext_f <= 1'b1;
                  end else if (r_shreg == c_brk_byte) begin
                     r_brk_f <= 1'b1;
                  end else begin
                     r_ext_f <= 1'b0;
                     r_brk_f <= 1'b0;
                     if (!r_key_valid || w_accept) begin
                        r_key_valid <= 1'b1;
                        r_key_code  <= r_shreg;
                        r_key_break <= r_brk_f;
                        r_key_ext   <= r_ext_f;
                     end else begin
                        r_overrun <= 1'b1;
                     end
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign key_valid = r_key_valid;
   assign key_code  = r_key_code;
   assign key_break = r_key_break;
   assign key_ext   = r_key_ext;
   assign frame_err = r_frame_err;
   assign err_code  = r_err_code;
   assign overrun   = r_overrun;
   assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ps2_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_frame_ctrl
//  Description : Directed self-checking bench for ps2_frame_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_frame_ctrl;

   localparam int TMO  = 64;
   localparam int HALF = 4;

   logic       fpgaclk = 1'b0;
   logic       rstreg  = 1'b1;
   logic       ps2clk  = 1'b1;
   logic       ps2data = 1'b1;
   logic       key_ready = 1'b0;
   logic       key_valid;
   logic [7:0] key_code;
   logic       key_break;
   logic       key_ext;
   logic       frame_err;
   logic [1:0] err_code;
   logic       overrun;
   logic       busy;

   int n_vec = 0;
   int n_err = 0;

   // event monitor: accepted events, valid cycles and error pulses
   int         acc_cnt = 0;
   logic [7:0] acc_code = 8'h00;
   logic       acc_brk = 1'b0;
   logic       acc_ext = 1'b0;
   int         vcyc = 0;
   int         ferr_cnt = 0;

   ps2_frame_ctrl #(.TIMEOUT_CYC(TMO), .CNT_W(7)) dut (
      .fpgaclk   (fpgaclk),
      .rstreg    (rstreg),
      .ps2clk    (ps2clk),
      .ps2data   (ps2data),
      .key_ready (key_ready),
      .key_valid (key_valid),
      .key_code  (key_code),
      .key_break (key_break),
      .key_ext   (key_ext),
      .frame_err (frame_err),
      .err_code  (err_code),
      .overrun   (overrun),
      .busy      (busy)
   );

   always #5 fpgaclk = ~fpgaclk;

   // record handshakes and pulses mid-cycle, away from the active edge
   always @(negedge fpgaclk) begin
      if (key_valid && key_ready) begin
         acc_cnt  <= acc_cnt + 1;
         acc_code <= key_code;
         acc_brk  <= key_break;
         acc_ext  <= key_ext;
      end
      if (key_valid) vcyc <= vcyc + 1;
      if (frame_err) ferr_cnt <= ferr_cnt + 1;
   end

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge fpgaclk);
         #2;
      end
   endtask

   function automatic logic [10:0] mk(input logic [7:0] b, input logic pflip,
                                      input logic stop);
      mk = {stop, (~^b) ^ pflip, b, 1'b0};
   endfunction

   task automatic send_bit(input logic b);
      ps2data = b;
      tick(HALF);
      ps2clk = 1'b0;
      tick(HALF);
      ps2clk = 1'b1;
   endtask

   task automatic send_range(input logic [10:0] f, input int lo, input int hi);
      for (int i = lo; i <= hi; i++) send_bit(f[i]);
   endtask

   task automatic send_frame(input logic [10:0] f);
      send_range(f, 0, 10);
      ps2data = 1'b1;
      tick(HALF);
   endtask

   task automatic pulse_ready();
      key_ready = 1'b1;
      tick();
      key_ready = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rstreg = 1'b1;
      tick(3);
      n_vec++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
      n_vec++; if (key_code !== 8'h00) begin n_err++; $display("FAIL reset_code got=%h exp=00", key_code); end
      n_vec++; if ({key_break, key_ext, frame_err, overrun, busy} !== 5'b0) begin n_err++; $display("FAIL reset_flags got=%b exp=00000", {key_break, key_ext, frame_err, overrun, busy}); end
      n_vec++; if (err_code !== 2'b00) begin n_err++; $display("FAIL reset_errcode got=%b exp=00", err_code); end
      rstreg = 1'b0;
      tick(2);
   endtask

   task automatic test_basic();
      int a0, v0;
      logic [10:0] f;
      f = mk(8'h1C, 1'b0, 1'b1);
      key_ready = 1'b1;
      a0 = acc_cnt; v0 = vcyc;
      send_range(f, 0, 5);
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_mid got=%b exp=1", busy); end
      send_range(f, 6, 10);
      ps2data = 1'b1;
      tick(HALF);
      n_vec++; if (acc_cnt - a0 !== 1) begin n_err++; $display("FAIL basic_accepts got=%0d exp=1", acc_cnt - a0); end
      n_vec++; if (vcyc - v0 !== 1) begin n_err++; $display("FAIL basic_valid_cycles got=%0d exp=1", vcyc - v0); end
      n_vec++; if ({acc_code, acc_brk, acc_ext} !== {8'h1C, 2'b00}) begin n_err++; $display("FAIL basic_event got=%h/%b%b exp=1c/00", acc_code, acc_brk, acc_ext); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_end got=%b exp=0", busy); end
      key_ready = 1'b0;
   endtask

   task automatic test_prefix();
      int a0;
      key_ready = 1'b0;
      a0 = acc_cnt;
      send_frame(mk(8'hE0, 1'b0, 1'b1));
      send_frame(mk(8'hF0, 1'b0, 1'b1));
      n_vec++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL prefix_no_event got=%b exp=0", key_valid); end
      send_frame(mk(8'h75, 1'b0, 1'b1));
      tick(10);
      n_vec++; if ({key_valid, key_code, key_break, key_ext} !== {1'b1, 8'h75, 2'b11}) begin n_err++; $display("FAIL prefix_hold got=%b/%h/%b%b exp=1/75/11", key_valid, key_code, key_break, key_ext); end
      pulse_ready();
      n_vec++; if (key_valid !== 1'b0 || acc_cnt - a0 !== 1) begin n_err++; $display("FAIL prefix_accept got=%b/%0d exp=0/1", key_valid, acc_cnt - a0); end
   endtask

   task automatic test_errors();
      int a0, e0;
      key_ready = 1'b1;
      a0 = acc_cnt; e0 = ferr_cnt;
      send_frame(mk(8'hE0, 1'b0, 1'b1));
      send_frame(mk(8'h1C, 1'b1, 1'b1));
      n_vec++; if (ferr_cnt - e0 !== 1) begin n_err++; $display("FAIL parity_pulse got=%0d exp=1", ferr_cnt - e0); end
      n_vec++; if (err_code !== 2'b01) begin n_err++; $display("FAIL parity_code got=%b exp=01", err_code); end
      n_vec++; if (acc_cnt - a0 !== 0) begin n_err++; $display("FAIL parity_no_event got=%0d exp=0", acc_cnt - a0); end
      send_frame(mk(8'hF0, 1'b0, 1'b1));
      send_frame(mk(8'h1C, 1'b0, 1'b1));
      n_vec++; if ({acc_code, acc_brk, acc_ext} !== {8'h1C, 2'b10} || acc_cnt - a0 !== 1) begin n_err++; $display("FAIL parity_recover got=%h/%b%b exp=1c/10", acc_code, acc_brk, acc_ext); end
      e0 = ferr_cnt;
      send_frame(mk(8'h33, 1'b0, 1'b0));
      n_vec++; if (ferr_cnt - e0 !== 1 || err_code !== 2'b10) begin n_err++; $display("FAIL stop_err got=%0d/%b exp=1/10", ferr_cnt - e0, err_code); end
      key_ready = 1'b0;
   endtask

   task automatic test_timeout();
      int a0, e0, t;
      key_ready = 1'b1;
      a0 = acc_cnt; e0 = ferr_cnt;
      send_range(mk(8'h29, 1'b0, 1'b1), 0, 4);
      ps2data = 1'b1;
      t = 0;
      while (ferr_cnt == e0 && t < 4 * TMO) begin tick(); t++; end
      n_vec++; if (ferr_cnt == e0) begin n_err++; $display("FAIL timeout_wait got=none exp=frame_err"); end
      tick(3);
      n_vec++; if (ferr_cnt - e0 !== 1 || err_code !== 2'b11) begin n_err++; $display("FAIL timeout_err got=%0d/%b exp=1/11", ferr_cnt - e0, err_code); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL timeout_idle got=%b exp=0", busy); end
      send_frame(mk(8'h29, 1'b0, 1'b1));
      n_vec++; if (acc_cnt - a0 !== 1 || {acc_code, acc_brk, acc_ext} !== {8'h29, 2'b00}) begin n_err++; $display("FAIL timeout_recover got=%0d/%h exp=1/29", acc_cnt - a0, acc_code); end
      n_vec++; if (err_code !== 2'b11) begin n_err++; $display("FAIL errcode_held got=%b exp=11", err_code); end
      key_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [10:0] f;
      key_ready = 1'b0;
      send_frame(mk(8'h1C, 1'b0, 1'b1));
      send_frame(mk(8'h32, 1'b0, 1'b1));
      n_vec++; if ({key_valid, key_code, overrun} !== {1'b1, 8'h1C, 1'b1}) begin n_err++; $display("FAIL overrun_drop got=%b/%h/%b exp=1/1c/1", key_valid, key_code, overrun); end
      pulse_ready();
      n_vec++; if ({key_valid, overrun} !== 2'b00) begin n_err++; $display("FAIL overrun_clear got=%b%b exp=00", key_valid, overrun); end
      send_frame(mk(8'h1C, 1'b0, 1'b1));
      send_frame(mk(8'h55, 1'b0, 1'b1));
      n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL overrun_again got=%b exp=1", overrun); end
      // stop bit of 0x32 timed so the accept lands on the event edge
      f = mk(8'h32, 1'b0, 1'b1);
      send_range(f, 0, 9);
      ps2data = 1'b1;
      tick(HALF);
      ps2clk = 1'b0;
      tick(2);
      key_ready = 1'b1;
      tick();
      key_ready = 1'b0;
      n_vec++; if ({key_valid, key_code, overrun} !== {1'b1, 8'h32, 1'b0}) begin n_err++; $display("FAIL coincident got=%b/%h/%b exp=1/32/0", key_valid, key_code, overrun); end
      tick(HALF);
      ps2clk = 1'b1;
      tick(HALF);
      pulse_ready();
      n_vec++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL coincident_drain got=%b exp=0", key_valid); end
   endtask

   task automatic test_midframe_reset();
      int a0;
      key_ready = 1'b0;
      send_frame(mk(8'h1C, 1'b0, 1'b1));
      send_frame(mk(8'h32, 1'b0, 1'b1));
      send_frame(mk(8'hE0, 1'b0, 1'b1));
      send_range(mk(8'h44, 1'b0, 1'b1), 0, 5);
      n_vec++; if ({busy, overrun, key_valid} !== 3'b111) begin n_err++; $display("FAIL prereset_state got=%b exp=111", {busy, overrun, key_valid}); end
      rstreg = 1'b1;
      tick();
      rstreg = 1'b0;
      ps2data = 1'b1;
      tick();
      n_vec++; if ({key_valid, key_code, key_break, key_ext, frame_err, err_code, overrun, busy} !== 15'b0) begin n_err++; $display("FAIL midreset_outputs got=%b exp=0", {key_valid, key_code, key_break, key_ext, frame_err, err_code, overrun, busy}); end
      key_ready = 1'b1;
      a0 = acc_cnt;
      send_frame(mk(8'h5A, 1'b0, 1'b1));
      n_vec++; if (acc_cnt - a0 !== 1 || {acc_code, acc_brk, acc_ext} !== {8'h5A, 2'b00}) begin n_err++; $display("FAIL midreset_recover got=%0d/%h/%b%b exp=1/5a/00", acc_cnt - a0, acc_code, acc_brk, acc_ext); end
      key_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_prefix();
      test_errors();
      test_timeout();
      test_back_to_back();
      test_midframe_reset();
      tick(4);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
